int_mem_stack_ctrl: RTL and testbench

// - Stack controller that sits directly upstream of the 8x4-bit internal memory (int_memory).
// - Turns PUSH/POP/PEEK commands from the core sequencer into the memory's ADR/DI/EN/WR strobes.
// - Captures read data returned on the memory's DO bus.
// - Owns the stack pointer and the FULL/EMPTY status flags.

---
 rtl/int_mem_stack_ctrl_pkg.sv | 21 ++
 rtl/int_stack_ptr.sv | 44 ++++
 rtl/int_mem_stack_ctrl.sv | 136 +++++++++++++
 tb/tb_int_mem_stack_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_mem_stack_ctrl_pkg.sv
// rtl/int_mem_stack_ctrl_pkg.sv - shared encodings and sizes for the internal-memory stack controller
package int_mem_stack_ctrl_pkg;

    localparam int INT_MEM_DEPTH = 8;
    localparam int INT_MEM_W     = 4;
    localparam int ADR_W         = 4;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_PEEK = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WRITE = 2'b01,
        S_READ  = 2'b10
    } state_e;

endpackage

// File: rtl/int_stack_ptr.sv
// rtl/int_stack_ptr.sv - up/down stack pointer with registered full/empty flags
module int_stack_ptr #(
    parameter int DEPTH = 8,
    parameter int SP_W  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    input  logic            dec,
    output logic [SP_W-1:0] sp,
    output logic [SP_W-1:0] sp_m1,
    output logic            full,
    output logic            empty
);

    logic [SP_W-1:0] sp_next;

    // clear outranks inc/dec so a flush during WRITE/READ still ends at zero
    always_comb begin
        sp_next = sp;
        if (clr)
            sp_next = '0;
        else if (inc)
            sp_next = sp + SP_W'(1);
        else if (dec)
            sp_next = sp - SP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp    <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            sp    <= sp_next;
            full  <= (sp_next == SP_W'(DEPTH));
            empty <= (sp_next == '0);
        end
    end

    assign sp_m1 = sp - SP_W'(1);

endmodule

// File: rtl/int_mem_stack_ctrl.sv
// rtl/int_mem_stack_ctrl.sv - PUSH/POP/PEEK stack controller driving the 8x4 internal memory
module int_mem_stack_ctrl
    import int_mem_stack_ctrl_pkg::*;
#(
    parameter int DEPTH = INT_MEM_DEPTH,
    parameter int W     = INT_MEM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    input  logic [W-1:0]     din,
    input  logic             flush,
    output logic             busy,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             err,
    output logic [ADR_W-1:0] mem_adr,
    output logic [W-1:0]     mem_di,
    output logic             mem_en,
    output logic             mem_wr,
    input  logic [W-1:0]     mem_do
);

    localparam int SP_W = $clog2(DEPTH + 1);

    state_e          state, state_next;
    logic [SP_W-1:0] sp, sp_m1;
    logic            sp_inc, sp_dec;
    logic            pop_q, pop_next;
    logic [ADR_W-1:0] adr_next;
    logic [W-1:0]    di_next, dout_next;
    logic            en_next, wr_next, dv_next, err_next;

    int_stack_ptr #(.DEPTH(DEPTH), .SP_W(SP_W)) u_sp (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (sp_inc),
        .dec   (sp_dec),
        .sp    (sp),
        .sp_m1 (sp_m1),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        adr_next   = mem_adr;
        di_next    = mem_di;
        en_next    = 1'b0;
        wr_next    = 1'b0;
        dout_next  = dout;
        dv_next    = 1'b0;
        err_next   = 1'b0;
        pop_next   = pop_q;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!flush && cmd_valid) begin
                    case (cmd)
                        CMD_PUSH: begin
                            if (!full) begin
                                state_next = S_WRITE;
                                adr_next   = ADR_W'(sp);
                                di_next    = din;
                                en_next    = 1'b1;
                                wr_next    = 1'b1;
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        CMD_POP, CMD_PEEK: begin
                            if (!empty) begin
                                state_next = S_READ;
                                adr_next   = ADR_W'(sp_m1);
                                en_next    = 1'b1;
                                pop_next   = (cmd == CMD_POP);
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: begin
                state_next = S_IDLE;
                sp_inc     = 1'b1;
            end
            S_READ: begin
                state_next = S_IDLE;
                dout_next  = mem_do;
                dv_next    = 1'b1;
                sp_dec     = pop_q;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // memory strobes come straight from flops so the gated write clock stays clean
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_adr    <= '0;
            mem_di     <= '0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            pop_q      <= 1'b0;
        end else begin
            mem_adr    <= adr_next;
            mem_di     <= di_next;
            mem_en     <= en_next;
            mem_wr     <= wr_next;
            dout       <= dout_next;
            dout_valid <= dv_next;
            err        <= err_next;
            pop_q      <= pop_next;
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_int_mem_stack_ctrl.sv
// tb/tb_int_mem_stack_ctrl.sv - directed vector bench for int_mem_stack_ctrl with 8x4 memory model
module tb_int_mem_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [3:0] din;
    logic       flush;
    logic       busy;
    logic [3:0] dout;
    logic       dout_valid;
    logic       full;
    logic       empty;
    logic       err;
    logic [3:0] mem_adr;
    logic [3:0] mem_di;
    logic       mem_en;
    logic       mem_wr;
    logic [3:0] mem_do;

    logic [3:0] mem [8];
    logic [7:0] wq [$];
    int total = 0;
    int bad   = 0;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] PEEK = 2'b11;

    always #5 clk = ~clk;

    int_mem_stack_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .din        (din),
        .flush      (flush),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .err        (err),
        .mem_adr    (mem_adr),
        .mem_di     (mem_di),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_do     (mem_do)
    );

    // behavioural 8x4 memory: edge write on clk&en, combinational read forced 0 when idle
    always @(posedge clk) begin
        if (mem_en && mem_wr) begin
            mem[mem_adr[2:0]] <= mem_di;
            wq.push_back({mem_adr, mem_di});
        end
    end
    assign mem_do = mem_en ? mem[mem_adr[2:0]] : 4'h0;

    typedef struct {
        logic       v;
        logic [1:0] c;
        logic [3:0] d;
        logic       f;
        logic       busy;
        logic       en;
        logic       wr;
        logic [3:0] adr;
        logic [3:0] di;
        logic       err;
        logic       dv;
        logic [3:0] dout;
        logic       full;
        logic       empty;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [1:0] c, input logic [3:0] d, input logic f);
        @(negedge clk);
        cmd_valid = v;
        cmd       = c;
        din       = d;
        flush     = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'h0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd = NOP; din = 4'h0; flush = 1'b0;

        //              v  c     d     f     busy en wr adr   di    err dv dout  full empty
        tbl[0]  = '{1'b1, PUSH, 4'hA, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, NOP,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hA, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, PUSH, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, NOP,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, PUSH, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, NOP,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, POP,  4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 4'hC, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, NOP,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'hC, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, POP,  4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h1, 4'hC, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, NOP,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 4'hC, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0};
        tbl[10] = '{1'b1, POP,  4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'hC, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0};
        tbl[11] = '{1'b0, NOP,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hC, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1};
        tbl[12] = '{1'b1, POP,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hC, 1'b1, 1'b0, 4'hA, 1'b0, 1'b1};
        tbl[13] = '{1'b0, NOP,  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'hC, 1'b0, 1'b0, 4'hA, 1'b0, 1'b1};

        // reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_dout", dout, 0);
        chk("rst_err", err, 0);
        chk("rst_dv", dout_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].f);
            chk($sformatf("v%0d_busy", i),  busy,       tbl[i].busy);
            chk($sformatf("v%0d_en", i),    mem_en,     tbl[i].en);
            chk($sformatf("v%0d_wr", i),    mem_wr,     tbl[i].wr);
            chk($sformatf("v%0d_adr", i),   mem_adr,    tbl[i].adr);
            chk($sformatf("v%0d_di", i),    mem_di,     tbl[i].di);
            chk($sformatf("v%0d_err", i),   err,        tbl[i].err);
            chk($sformatf("v%0d_dv", i),    dout_valid, tbl[i].dv);
            chk($sformatf("v%0d_dout", i),  dout,       tbl[i].dout);
            chk($sformatf("v%0d_full", i),  full,       tbl[i].full);
            chk($sformatf("v%0d_empty", i), empty,      tbl[i].empty);
        end
        chk("wr_count", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("wr0", wq[0], 8'h0A);
            chk("wr1", wq[1], 8'h15);
            chk("wr2", wq[2], 8'h2C);
        end

        // fill to FULL, reject 9th push, peek top
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, PUSH, 4'(i), 1'b0);
            chk($sformatf("fill%0d_adr", i), mem_adr, i);
            chk($sformatf("fill%0d_wr", i), mem_wr, 1);
            cyc(1'b0, NOP, 4'h0, 1'b0);
            chk($sformatf("fill%0d_full", i), full, (i == 7));
        end
        cyc(1'b1, PUSH, 4'hF, 1'b0);
        chk("ovf_err", err, 1);
        chk("ovf_en", mem_en, 0);
        chk("ovf_full", full, 1);
        cyc(1'b0, NOP, 4'h0, 1'b0);
        chk("ovf_err_clr", err, 0);
        cyc(1'b1, PEEK, 4'h0, 1'b0);
        chk("peek_adr", mem_adr, 7);
        chk("peek_wr", mem_wr, 0);
        cyc(1'b0, NOP, 4'h0, 1'b0);
        chk("peek_dout", dout, 7);
        chk("peek_dv", dout_valid, 1);
        chk("peek_full", full, 1);
        cyc(1'b1, PEEK, 4'h0, 1'b0);
        chk("peek2_adr", mem_adr, 7);
        cyc(1'b0, NOP, 4'h0, 1'b0);

        cyc(1'b0, NOP, 4'h0, 1'b1);
        chk("flush_idle_empty", empty, 1);
        chk("flush_idle_full", full, 0);

        // command while busy is ignored
        wq.delete();
        cyc(1'b1, PUSH, 4'h3, 1'b0);
        cyc(1'b1, PUSH, 4'h9, 1'b0);
        chk("busy_err", err, 0);
        chk("busy_done", busy, 0);
        chk("busy_empty", empty, 0);
        cyc(1'b0, NOP, 4'h0, 1'b0);
        chk("busy_en", mem_en, 0);
        chk("busy_wcount", wq.size(), 1);
        chk("busy_mem0", mem[0], 3);
        cyc(1'b1, POP, 4'h0, 1'b0);
        cyc(1'b0, NOP, 4'h0, 1'b0);
        chk("busy_pop_dout", dout, 3);
        chk("busy_pop_empty", empty, 1);

        // flush during WRITE
        cyc(1'b1, PUSH, 4'h6, 1'b0);
        cyc(1'b0, NOP, 4'h0, 1'b1);
        chk("fw_empty", empty, 1);
        chk("fw_busy", busy, 0);
        chk("fw_mem0", mem[0], 6);
        cyc(1'b1, POP, 4'h0, 1'b0);
        chk("fw_pop_err", err, 1);
        chk("fw_pop_en", mem_en, 0);

        // flush during READ
        cyc(1'b1, PUSH, 4'h4, 1'b0);
        cyc(1'b0, NOP, 4'h0, 1'b0);
        cyc(1'b1, PUSH, 4'h2, 1'b0);
        cyc(1'b0, NOP, 4'h0, 1'b0);
        cyc(1'b1, POP, 4'h0, 1'b0);
        cyc(1'b0, NOP, 4'h0, 1'b1);
        chk("fr_dv", dout_valid, 1);
        chk("fr_dout", dout, 2);
        chk("fr_empty", empty, 1);

        // reset during WRITE: write lands, strobe drops
        cyc(1'b1, PUSH, 4'h8, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_en", mem_en, 0);
        chk("rstw_mem0", mem[0], 8);
        chk("rstw_empty", empty, 1);
        chk("rstw_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
